// File: rtl/controle_ciclo_pkg.sv
// controle_ciclo_pkg: state codes and lamp/motor output encoding for the ride sequencer
package controle_ciclo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BOARD  = 3'd1,
        RUN    = 3'd2,
        SLOW   = 3'd3,
        UNLOAD = 3'd4,
        EMERG  = 3'd5
    } state_t;

    // {on_off, bit1, bit0, motor} for each state
    function automatic logic [3:0] enc(input state_t s);
        return s == BOARD  ? 4'b1100 :
               s == RUN    ? 4'b1001 :
               s == SLOW   ? 4'b1011 :
               s == UNLOAD ? 4'b1110 :
               s == EMERG  ? 4'b1000 : 4'b0000;
    endfunction

endpackage

// File: rtl/controle_ciclo_gerador_tick.sv
// gerador_tick: 1 s tick prescaler with synchronous clear
module gerador_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] cnt;

    assign tick = cnt == PW'(TICK_DIV - 1);

    // count 0..TICK_DIV-1, restarting on every state change
    always_ff @(posedge clk) begin
        if (reset || clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/controle_ciclo.sv
// controle_ciclo: ride cycle sequencer with phase timing, interlock and emergency stop
module controle_ciclo
    import controle_ciclo_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int T_BOARD  = 2,
    parameter int T_RUN    = 8,
    parameter int T_SLOW   = 4,
    parameter int T_UNLOAD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       seat_ok,
    input  logic       emerg,
    output logic       on_off,
    output logic       bit0,
    output logic       bit1,
    output logic       motor,
    output logic       busy,
    output logic       done,
    output logic [2:0] fase
);

    localparam int TMAX = T_BOARD > T_RUN ? (T_BOARD > T_SLOW ? (T_BOARD > T_UNLOAD ? T_BOARD : T_UNLOAD)
                                                              : (T_SLOW > T_UNLOAD ? T_SLOW : T_UNLOAD))
                                          : (T_RUN > T_SLOW ? (T_RUN > T_UNLOAD ? T_RUN : T_UNLOAD)
                                                            : (T_SLOW > T_UNLOAD ? T_SLOW : T_UNLOAD));
    localparam int TW = $clog2(TMAX + 1);

    state_t        state, nxt;
    logic          tick, clr, timed, timeout;
    logic [TW-1:0] tcnt, lim;

    gerador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    // phase length selection and timeout on the last tick of the phase
    always_comb begin
        lim = state == BOARD  ? TW'(T_BOARD - 1)  :
              state == RUN    ? TW'(T_RUN - 1)    :
              state == SLOW   ? TW'(T_SLOW - 1)   :
              state == UNLOAD ? TW'(T_UNLOAD - 1) : '0;
        timed   = state != IDLE && state != EMERG;
        timeout = timed && tick && tcnt == lim;
    end

    // next state: emergency first, then interlock, then phase timeout
    always_comb begin
        nxt = state;
        if (emerg && state != EMERG)
            nxt = EMERG;
        else
            case (state)
                IDLE:    nxt = start && seat_ok ? BOARD : IDLE;
                BOARD:   nxt = timeout ? RUN : BOARD;
                RUN:     nxt = !seat_ok ? EMERG : timeout ? SLOW : RUN;
                SLOW:    nxt = !seat_ok ? EMERG : timeout ? UNLOAD : SLOW;
                UNLOAD:  nxt = timeout ? IDLE : UNLOAD;
                EMERG:   nxt = emerg ? EMERG : UNLOAD;
                default: nxt = IDLE;
            endcase
        clr = nxt != state;
    end

    // state, phase tick counter and registered Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= IDLE;
            tcnt                       <= '0;
            {on_off, bit1, bit0, motor} <= 4'b0000;
            busy                       <= 1'b0;
            done                       <= 1'b0;
            fase                       <= 3'd0;
        end else begin
            state                      <= nxt;
            tcnt                       <= clr ? '0 : (timed && tick) ? tcnt + 1'b1 : tcnt;
            {on_off, bit1, bit0, motor} <= enc(nxt);
            busy                       <= nxt != IDLE;
            done                       <= state == UNLOAD && nxt == IDLE;
            fase                       <= nxt;
        end
    end

endmodule
